// File: rtl/exhaustive_stim_checker.sv
// rtl/exhaustive_stim_checker.sv - exhaustive 2^N_IN stimulus sweep with DUT/golden compare
//
// Purpose: drives every input vector 0 .. 2^N_IN-1 once, holds each for
// LATENCY cycles, compares DUT against golden model on the last held cycle
// and reports error count, first failing vector and pass/done status.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   start           single-cycle sweep request, ignored while busy
//   stop_on_err     sampled with start; end sweep at first mismatch
//   stim_o          vector driven to DUT and golden model
//   dut_out_i       DUT response
//   exp_out_i       golden-model response
//   busy            sweep in progress
//   done            sweep finished, held until next accepted start
//   pass            valid with done; 1 iff no mismatch
//   err_count       mismatching vectors, saturating
//   first_err_valid at least one mismatch this sweep
//   first_err_vec   vector of the first mismatch

module exhaustive_stim_checker #(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 1,
    parameter int LATENCY = 1,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_err,
    output logic [N_IN-1:0]  stim_o,
    input  logic [N_OUT-1:0] dut_out_i,
    input  logic [N_OUT-1:0] exp_out_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
);

    localparam int HW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(LATENCY - 1);
    localparam logic [N_IN-1:0]  VEC_LAST  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [HW-1:0]    hold_cnt, hold_cnt_n;
    logic             stop_lat, stop_lat_n;
    logic [N_IN-1:0]  stim_n;
    logic             done_n, pass_n;
    logic [ERR_W-1:0] err_count_n;
    logic             first_err_valid_n;
    logic [N_IN-1:0]  first_err_vec_n;
    logic             mismatch;

    assign busy     = (state == S_RUN);
    assign mismatch = (dut_out_i != exp_out_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            hold_cnt        <= '0;
            stop_lat        <= 1'b0;
            stim_o          <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            state           <= state_n;
            hold_cnt        <= hold_cnt_n;
            stop_lat        <= stop_lat_n;
            stim_o          <= stim_n;
            done            <= done_n;
            pass            <= pass_n;
            err_count       <= err_count_n;
            first_err_valid <= first_err_valid_n;
            first_err_vec   <= first_err_vec_n;
        end
    end

    always_comb begin
        state_n           = state;
        hold_cnt_n        = hold_cnt;
        stop_lat_n        = stop_lat;
        stim_n            = stim_o;
        done_n            = done;
        pass_n            = pass;
        err_count_n       = err_count;
        first_err_valid_n = first_err_valid;
        first_err_vec_n   = first_err_vec;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n           = S_RUN;
                    hold_cnt_n        = '0;
                    stop_lat_n        = stop_on_err;
                    stim_n            = '0;
                    done_n            = 1'b0;
                    pass_n            = 1'b0;
                    err_count_n       = '0;
                    first_err_valid_n = 1'b0;
                    first_err_vec_n   = '0;
                end
            end
            S_RUN: begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end else begin
                    // Compare cycle: the DUT has had LATENCY cycles to settle.
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count_n = err_count + 1'b1;
                        end
                        if (!first_err_valid) begin
                            first_err_valid_n = 1'b1;
                            first_err_vec_n   = stim_o;
                        end
                    end
                    // End on the all-ones vector rather than on counter wrap,
                    // so stim_o keeps the last applied vector in DONE.
                    if ((stim_o == VEC_LAST) || (mismatch && stop_lat)) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        pass_n  = !first_err_valid && !mismatch;
                    end else begin
                        stim_n     = stim_o + 1'b1;
                        hold_cnt_n = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
